// File: rtl/cache_tag_lookup.sv
// Set-associative cache tag store with a registered 1-cycle lookup,
// direct fill port, per-set round-robin victim pointer and a
// one-set-per-cycle flush sequencer.
module cache_tag_lookup #(
  parameter int TAG_W = 3,
  parameter int IDX_W = 3,
  parameter int WAYS  = 2,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_write,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  output logic             resp_victim_dirty,
  output logic [TAG_W-1:0] resp_victim_tag,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             fill_dirty,
  input  logic             flush,
  output logic             busy
);

  localparam int unsigned SETS  = 1 << IDX_W;
  localparam int unsigned NWAYS = WAYS;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] flush_cnt;
  logic             flush_clear;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAY_W-1:0] ptr_q   [SETS];

  logic             accept;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim_way;
  logic             fill_ok;
  logic [WAY_W-1:0] fill_next_ptr;

  assign busy      = (state_q == FLUSH);
  assign req_ready = !reset && !fill_valid && !busy;
  assign accept    = req_valid && req_ready;

  // With a single way the pointer is pinned at 0 and only way 0 is writable.
  assign fill_ok       = (WAYS > 1) || (fill_way == '0);
  assign fill_next_ptr = (WAYS > 1) ? fill_way + WAY_W'(1) : '0;

  // Flush sequencer state register and set counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      flush_cnt <= '0;
    end else begin
      state_q   <= state_d;
      flush_cnt <= (state_q == FLUSH) ? flush_cnt + IDX_W'(1) : '0;
    end
  end

  // Flush next-state: start on a pulse in IDLE, leave after the last set.
  always_comb begin
    state_d     = state_q;
    flush_clear = 1'b0;
    case (state_q)
      IDLE:  if (flush) state_d = FLUSH;
      FLUSH: begin
        flush_clear = 1'b1;
        if (&flush_cnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag compare (lowest matching way wins) and victim selection.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < NWAYS; w++) begin
      if (!hit && valid_q[req_index][WAY_W'(w)] &&
          tag_q[req_index][WAY_W'(w)] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[req_index][WAY_W'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_way = inv_found ? inv_way : ptr_q[req_index];
  end

  // Tag store: reset, flush clearing, fills and write-hit dirty marking.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[IDX_W'(s)] <= '0;
        dirty_q[IDX_W'(s)] <= '0;
        ptr_q[IDX_W'(s)]   <= '0;
        for (int unsigned w = 0; w < NWAYS; w++) begin
          tag_q[IDX_W'(s)][WAY_W'(w)] <= '0;
        end
      end
    end else if (flush_clear) begin
      valid_q[flush_cnt] <= '0;
      dirty_q[flush_cnt] <= '0;
      ptr_q[flush_cnt]   <= '0;
    end else if (fill_valid) begin
      if (fill_ok) begin
        valid_q[fill_index][fill_way] <= 1'b1;
        dirty_q[fill_index][fill_way] <= fill_dirty;
        tag_q[fill_index][fill_way]   <= fill_tag;
        ptr_q[fill_index]             <= fill_next_ptr;
      end
    end else if (accept && hit && req_write) begin
      dirty_q[req_index][hit_way] <= 1'b1;
    end
  end

  // Registered lookup response; victim fields are zero on a hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid        <= 1'b0;
      resp_hit          <= 1'b0;
      resp_way          <= '0;
      resp_victim_dirty <= 1'b0;
      resp_victim_tag   <= '0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_hit          <= hit;
        resp_way          <= hit ? hit_way : victim_way;
        resp_victim_dirty <= hit ? 1'b0 :
                             (valid_q[req_index][victim_way] & dirty_q[req_index][victim_way]);
        resp_victim_tag   <= hit ? '0 : tag_q[req_index][victim_way];
      end
    end
  end

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Self-checking bench for cache_tag_lookup: directed scenarios plus a
// randomized fill/lookup mix checked against an array-based reference model.
module tb_cache_tag_lookup;

  localparam int TAG_W = 3;
  localparam int IDX_W = 3;
  localparam int WAYS  = 2;
  localparam int WAY_W = 1;
  localparam int SETS  = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;
  logic             req_write;
  logic             resp_valid;
  logic             resp_hit;
  logic [WAY_W-1:0] resp_way;
  logic             resp_victim_dirty;
  logic [TAG_W-1:0] resp_victim_tag;
  logic             fill_valid;
  logic [IDX_W-1:0] fill_index;
  logic [WAY_W-1:0] fill_way;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_dirty;
  logic             flush;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Reference model of the tag store.
  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  bit m_known [SETS][WAYS];
  int m_ptr   [SETS];

  cache_tag_lookup #(.TAG_W(TAG_W), .IDX_W(IDX_W), .WAYS(WAYS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_tag(req_tag), .req_write(req_write),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_victim_dirty(resp_victim_dirty), .resp_victim_tag(resp_victim_tag),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_dirty(fill_dirty),
    .flush(flush), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_known[s][w] = 0;
      end
    end
  endfunction

  function automatic void m_flush();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    end
  endfunction

  function automatic void m_fill(input int idx, input int way, input int tag, input bit d);
    m_valid[idx][way] = 1;
    m_dirty[idx][way] = d;
    m_tag[idx][way]   = tag;
    m_known[idx][way] = 1;
    m_ptr[idx]        = (way + 1) % WAYS;
  endfunction

  task automatic m_expect(input int idx, input int tag, output bit hit, output int way,
                          output bit vd, output int vt, output bit vt_known);
    hit = 0; way = 0; vd = 0; vt = 0; vt_known = 1;
    for (int w = 0; w < WAYS; w++)
      if (!hit && m_valid[idx][w] && m_tag[idx][w] == tag) begin
        hit = 1;
        way = w;
      end
    if (!hit) begin
      way = m_ptr[idx];
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[idx][w]) way = w;
      vd       = m_valid[idx][way] && m_dirty[idx][way];
      vt       = m_tag[idx][way];
      vt_known = m_known[idx][way];
    end
  endtask

  task automatic idle_inputs();
    req_valid  = 0; req_index = '0; req_tag = '0; req_write = 0;
    fill_valid = 0; fill_index = '0; fill_way = '0; fill_tag = '0; fill_dirty = 0;
    flush      = 0;
  endtask

  task automatic do_lookup(input int idx, input int tag, input bit wr, input string name,
                           output bit o_hit, output int o_way, output bit o_vd, output int o_vt);
    bit e_hit, e_vd, e_known;
    int e_way, e_vt;
    m_expect(idx, tag, e_hit, e_way, e_vd, e_vt, e_known);
    req_valid = 1; req_index = IDX_W'(idx); req_tag = TAG_W'(tag); req_write = wr;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready: got %b expected 1", name, req_ready);
    end
    next();
    req_valid = 0; req_write = 0;
    if (e_hit && wr) m_dirty[idx][e_way] = 1;
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL %s resp_valid: got %b expected 1", name, resp_valid);
    end
    checks++;
    if (resp_hit !== e_hit) begin
      errors++; $display("FAIL %s resp_hit: got %b expected %b", name, resp_hit, e_hit);
    end
    checks++;
    if (resp_way !== WAY_W'(e_way)) begin
      errors++; $display("FAIL %s resp_way: got %0d expected %0d", name, resp_way, e_way);
    end
    checks++;
    if (resp_victim_dirty !== e_vd) begin
      errors++; $display("FAIL %s resp_victim_dirty: got %b expected %b", name, resp_victim_dirty, e_vd);
    end
    if (e_known) begin
      checks++;
      if (resp_victim_tag !== TAG_W'(e_vt)) begin
        errors++; $display("FAIL %s resp_victim_tag: got %0d expected %0d", name, resp_victim_tag, e_vt);
      end
    end
    o_hit = resp_hit; o_way = int'(resp_way); o_vd = resp_victim_dirty; o_vt = int'(resp_victim_tag);
  endtask

  task automatic do_fill(input int idx, input int way, input int tag, input bit d,
                         input bit with_req, input string name);
    fill_valid = 1; fill_index = IDX_W'(idx); fill_way = WAY_W'(way);
    fill_tag = TAG_W'(tag); fill_dirty = d;
    if (with_req) begin
      req_valid = 1; req_index = IDX_W'($urandom_range(0, SETS - 1));
      req_tag = TAG_W'($urandom_range(0, 7)); req_write = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++; $display("FAIL %s req_ready with fill: got %b expected 0", name, req_ready);
      end
    end
    next();
    fill_valid = 0; req_valid = 0; req_write = 0;
    m_fill(idx, way, tag, d);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL %s resp_valid after fill: got %b expected 0", name, resp_valid);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    req_valid = 1; req_index = 3'd2; req_tag = 3'd5;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset req_ready: got %b expected 0", req_ready);
    end
    next();
    next();
    checks++;
    if ({resp_valid, resp_hit, resp_way, resp_victim_dirty, resp_victim_tag, busy} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got v%b h%b w%0d d%b t%0d busy%b expected all 0",
               resp_valid, resp_hit, resp_way, resp_victim_dirty, resp_victim_tag, busy);
    end
    reset = 0;
    req_valid = 0;
    m_reset();
    next();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset no_response: got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_directed();
    bit h, vd;
    int w, vt;
    do_lookup(2, 5, 0, "dir_empty", h, w, vd, vt);
    checks++;
    if (h !== 0 || w != 0 || vd !== 0) begin
      errors++; $display("FAIL dir_empty: got hit%b way%0d vd%b expected hit0 way0 vd0", h, w, vd);
    end
    do_fill(2, 0, 5, 0, 0, "dir_fill0");
    do_lookup(2, 5, 1, "dir_hit_wr", h, w, vd, vt);
    checks++;
    if (h !== 1 || w != 0) begin
      errors++; $display("FAIL dir_hit_wr: got hit%b way%0d expected hit1 way0", h, w);
    end
    do_lookup(2, 5, 0, "dir_hit", h, w, vd, vt);
    checks++;
    if (h !== 1 || w != 0 || vd !== 0 || vt != 0) begin
      errors++; $display("FAIL dir_hit: got hit%b way%0d vd%b vt%0d expected hit1 way0 vd0 vt0", h, w, vd, vt);
    end
    do_lookup(2, 4, 0, "dir_miss_inv", h, w, vd, vt);
    checks++;
    if (h !== 0 || w != 1) begin
      errors++; $display("FAIL dir_miss_inv: got hit%b way%0d expected hit0 way1", h, w);
    end
    do_fill(2, 1, 4, 1, 0, "dir_fill1");
    do_lookup(2, 7, 0, "dir_victim", h, w, vd, vt);
    checks++;
    if (h !== 0 || w != 0 || vd !== 1 || vt != 5) begin
      errors++; $display("FAIL dir_victim: got hit%b way%0d vd%b vt%0d expected hit0 way0 vd1 vt5", h, w, vd, vt);
    end
  endtask

  task automatic test_fill_priority();
    bit h, vd;
    int w, vt;
    fill_valid = 1; fill_index = 3'd3; fill_way = 1'b1; fill_tag = 3'd6; fill_dirty = 0;
    req_valid = 1; req_index = 3'd3; req_tag = 3'd6; req_write = 0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL prio req_ready: got %b expected 0", req_ready);
    end
    next();
    idle_inputs();
    m_fill(3, 1, 6, 0);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL prio resp_valid: got %b expected 0", resp_valid);
    end
    do_lookup(3, 6, 0, "prio_written", h, w, vd, vt);
    checks++;
    if (h !== 1 || w != 1) begin
      errors++; $display("FAIL prio_written: got hit%b way%0d expected hit1 way1", h, w);
    end
  endtask

  task automatic test_flush();
    bit h, vd;
    int w, vt, cnt;
    do_fill(1, 0, 2, 1, 0, "fl_pre0");
    do_fill(1, 1, 3, 0, 0, "fl_pre1");
    do_fill(6, 1, 7, 1, 0, "fl_pre2");
    flush = 1;
    next();
    flush = 0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      flush      = (cnt == 2);
      fill_valid = (cnt == 4); fill_index = 3'd5; fill_way = 1'b0; fill_tag = 3'd3; fill_dirty = 1;
      req_valid  = 1; req_index = 3'd1; req_tag = 3'd2;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++; $display("FAIL flush req_ready cycle %0d: got %b expected 0", cnt, req_ready);
      end
      next();
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL flush resp_valid cycle %0d: got %b expected 0", cnt, resp_valid);
      end
      cnt++;
    end
    idle_inputs();
    m_flush();
    checks++;
    if (cnt != SETS) begin
      errors++; $display("FAIL flush busy_cycles: got %0d expected %0d", cnt, SETS);
    end
    next();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush busy_after: got %b expected 0", busy);
    end
    for (int s = 0; s < SETS; s++) begin
      int t;
      t = (s == 1) ? 2 : (s == 5) ? 3 : (s == 6) ? 7 : s;
      do_lookup(s, t, 0, "flush_miss", h, w, vd, vt);
      checks++;
      if (h !== 0 || w != 0) begin
        errors++; $display("FAIL flush_miss set %0d: got hit%b way%0d expected hit0 way0", s, h, w);
      end
    end
  endtask

  task automatic test_flush_reset();
    bit h, vd;
    int w, vt;
    do_fill(4, 0, 1, 1, 0, "flr_pre");
    flush = 1;
    next();
    flush = 0;
    next();
    next();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL flr busy_cycle3: got %b expected 1", busy);
    end
    reset = 1;
    next();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL flr abort: got busy%b resp_valid%b expected 0 0", busy, resp_valid);
    end
    reset = 0;
    m_reset();
    next();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flr stay_idle: got %b expected 0", busy);
    end
    do_lookup(4, 1, 0, "flr_cleared", h, w, vd, vt);
    checks++;
    if (h !== 0 || w != 0 || vd !== 0) begin
      errors++; $display("FAIL flr_cleared: got hit%b way%0d vd%b expected 0 0 0", h, w, vd);
    end
  endtask

  task automatic test_random();
    bit h, vd;
    int w, vt, op;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5)
        do_lookup($urandom_range(0, SETS - 1), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                  "rand_lookup", h, w, vd, vt);
      else
        do_fill($urandom_range(0, SETS - 1), $urandom_range(0, WAYS - 1), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), op == 9, "rand_fill");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_fill_priority();
    test_flush();
    test_flush_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_tag_lookup.md
CACHE_TAG_LOOKUP -- requirements
Module: cache_tag_lookup

Interface
REQ-001 The block SHALL have parameter TAG_W, default 3, giving the tag width in bits.
REQ-002 The block SHALL have parameter IDX_W, default 3, giving the set index width; the block holds SETS = 2^IDX_W sets.
REQ-003 The block SHALL have parameter WAYS, default 2, a power of two >= 1, giving the associativity; WAY_W = max(1, log2(WAYS)).
REQ-004 The block SHALL have the following ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  lookup accepted this cycle when high with req_valid.
- req_index  in  IDX_W  set to search.
- req_tag  in  TAG_W  tag to compare.
- req_write  in  1  on hit, mark the hit line dirty.
- resp_valid  out  1  response strobe, one cycle.
- resp_hit  out  1  tag match on a valid way.
- resp_way  out  WAY_W  hit way if hit, else victim way.
- resp_victim_dirty  out  1  victim line valid and dirty (miss only).
- resp_victim_tag  out  TAG_W  stored tag of victim (miss only).
- fill_valid  in  1  write a line into the tag store.
- fill_index  in  IDX_W  set to write.
- fill_way  in  WAY_W  way to write.
- fill_tag  in  TAG_W  tag to store.
- fill_dirty  in  1  initial dirty bit of filled line.
- flush  in  1  one-cycle pulse starting a full invalidate.
- busy  out  1  flush in progress.

Function
REQ-005 Storage SHALL be SETS x WAYS entries of {valid, dirty, tag} plus one WAY_W round-robin pointer per set.
REQ-006 Lookup SHALL have 1-cycle latency: a request accepted at edge N produces resp_valid=1 for exactly the cycle after edge N, with all resp_* outputs registered.
REQ-007 Hit SHALL be asserted when any way in the set has valid=1 and stored tag equal to req_tag in all TAG_W bits; if several ways match, the lowest-numbered way SHALL be reported.
REQ-008 On a hit with req_write=1, the dirty bit of the hit way SHALL be set at the same edge the response is registered; resp_victim_dirty and resp_victim_tag SHALL be 0 on a hit.
REQ-009 On a miss, the victim SHALL be the lowest-numbered invalid way in the set, else the way named by the set's round-robin pointer; resp_victim_dirty = valid&dirty of that way, resp_victim_tag = its stored tag.
REQ-010 A lookup SHALL NOT modify any valid bit, tag or pointer.
REQ-011 A fill SHALL write valid=1, tag=fill_tag, dirty=fill_dirty into (fill_index, fill_way) and set that set's pointer to (fill_way+1) mod WAYS, wrapping from WAYS-1 to 0.
REQ-012 req_ready SHALL be 0 whenever fill_valid=1 or busy=1, else 1; fill has priority, so a lookup is never compared against a half-written set.
REQ-013 The block SHALL implement states IDLE and FLUSH: flush=1 in IDLE moves to FLUSH with a set counter at 0; in FLUSH one set per cycle has all valid and dirty bits cleared and its pointer set to 0; after set SETS-1 the state returns to IDLE, so busy is high for exactly SETS cycles.
REQ-014 flush asserted while busy=1 SHALL be ignored; fill_valid during FLUSH SHALL be ignored.
REQ-015 With WAYS=1 the victim SHALL always be way 0 and the pointer SHALL stay at 0.

Reset
REQ-016 When reset=1 at a clock edge, the block SHALL clear all valid and dirty bits, set all pointers to 0, enter IDLE, and drive resp_valid, resp_hit, resp_way, resp_victim_dirty, resp_victim_tag and busy to 0; req_ready SHALL be 0 while reset=1.
REQ-017 Reset SHALL abort an in-progress flush or pending response; no resp_valid SHALL appear for a request accepted in the cycle reset is high.

Verification
REQ-018 Reset, then lookup index 2 tag 5 -> one cycle later resp_valid=1, resp_hit=0, resp_way=0, resp_victim_dirty=0.
REQ-019 Fill (2, way 0, tag 5, dirty 0), lookup (2, tag 5, write 1), then lookup (2, tag 5) -> both hit way 0; lookup (2, tag 4) -> miss, resp_way=1 (invalid way).
REQ-020 Fill (2, way 1, tag 4, dirty 1), lookup (2, tag 7) -> miss, resp_way=0, resp_victim_dirty=1, resp_victim_tag=5 (pointer wrapped to 0).
REQ-021 Assert fill_valid and req_valid together -> req_ready=0, no response that cycle, fill written.
REQ-022 Pulse flush -> busy high 8 cycles (defaults), req_ready low; then every lookup misses with resp_way=0; assert reset at flush cycle 3 -> busy=0 next cycle.
